mc_mem_responder: RTL and testbench

- Memory-side responder for the 16-bit multicycle CPU's unified instruction/data memory port, i.e. the adr / writedata / readdata bus.
- Accepts one read or write request at a time from the multicycle controller and holds it for a programmable number of wait states.
- Completes each request with a one-cycle ready pulse.
- readdata stays stable between reads, so the CPU's instruction and data registers can sample it in any later state.

---
 rtl/mc_mem_pkg.sv | 7 +
 rtl/mc_mem_responder_if.sv | 14 +
 rtl/mc_mem_array.sv | 26 ++
 rtl/mc_mem_responder.sv | 91 +++++++++
 tb/tb_mc_mem_responder.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/mc_mem_pkg.sv
// mc_mem_pkg: shared types and constants for the multicycle CPU memory responder.
package mc_mem_pkg;
    localparam int WORD_W = 16;
    localparam int CNT_W = 4;
    localparam logic [WORD_W-1:0] ERR_DATA = 16'h0000;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mc_mem_responder_if.sv
// mc_mem_responder_if: CPU memory-port bus; master = CPU controller, slave = responder.
// Signals: req/we/adr/writedata (master->slave), readdata/ready/busy/err (slave->master).
interface mc_mem_responder_if;
    logic        req;
    logic        we;
    logic [15:0] adr;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        ready;
    logic        busy;
    logic        err;
    modport master (output req, we, adr, writedata, input readdata, ready, busy, err);
    modport slave (input req, we, adr, writedata, output readdata, ready, busy, err);
endinterface

// File: rtl/mc_mem_array.sv
// mc_mem_array: single-port 2^ADDR_W x 16 memory with synchronous write and registered read.
// Ports: clk, rst (clears only the read register), i_wen, i_ren, i_addr, i_wdata, o_rdata.
// o_rdata changes only on a read enable, so it holds between reads.
module mc_mem_array
    import mc_mem_pkg::*;
#(
    parameter int    ADDR_W    = 8,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wen,
    input  logic              i_ren,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);
    logic [WORD_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk)
        if (i_wen) r_mem[i_addr] <= i_wdata;

    always_ff @(posedge clk)
        if (rst) o_rdata <= '0;
        else if (i_ren) o_rdata <= r_mem[i_addr];
endmodule

// File: rtl/mc_mem_responder.sv
// mc_mem_responder: memory-side responder holding each request LATENCY wait states, then a ready pulse.
// Ports: clk, reset (sync, active-high), bus (mc_mem_responder_if.slave).
// Optional macro MC_MEM_BOUNDS_CHECK_EN: flags out-of-range addresses with err, suppresses the access.
module mc_mem_responder
    import mc_mem_pkg::*;
#(
    parameter int    ADDR_W    = 8,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic clk,
    input  logic reset,
    mc_mem_responder_if.slave bus
);
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [WORD_W-1:0] r_adr;
    logic [WORD_W-1:0] r_wd;
    logic              r_zero;
    logic              r_err;
    logic              w_acc;
    logic              w_we;
    logic              w_oor;
    logic              w_wen;
    logic              w_ren;
    logic [WORD_W-1:0] w_adr;
    logic [WORD_W-1:0] w_wd;
    logic [WORD_W-1:0] w_q;
    logic              w_unused;

    // With zero latency the access uses the live bus at the acceptance edge.
    always_comb begin
        w_we  = r_state == IDLE ? bus.we : r_we;
        w_adr = r_state == IDLE ? bus.adr : r_adr;
        w_wd  = r_state == IDLE ? bus.writedata : r_wd;
        w_acc = (r_state == IDLE && bus.req && LATENCY == 0) || (r_state == WAIT && r_cnt == '0);
`ifdef MC_MEM_BOUNDS_CHECK_EN
        w_oor = |(w_adr >> (ADDR_W + 2));
`else
        w_oor = 1'b0;
`endif
        // Reset landing on an access edge discards that access.
        w_wen = w_acc & w_we & ~w_oor & ~reset;
        w_ren = w_acc & ~w_we & ~w_oor & ~reset;
    end

    assign w_unused = ^{w_adr[1:0], w_adr[WORD_W-1:ADDR_W+2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // An out-of-range read masks the array output until the next read.
            if (w_acc && !w_we) r_zero <= w_oor;
            r_err <= w_acc & w_oor;
            case (r_state)
                IDLE: if (bus.req) begin
                    r_we    <= bus.we;
                    r_adr   <= bus.adr;
                    r_wd    <= bus.writedata;
                    r_cnt   <= CNT_W'(LATENCY - 1);
                    r_state <= LATENCY == 0 ? RESP : WAIT;
                end
                WAIT: begin
                    r_cnt   <= r_cnt - 1'b1;
                    r_state <= r_cnt == '0 ? RESP : WAIT;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    mc_mem_array #(.ADDR_W(ADDR_W), .INIT_FILE(INIT_FILE)) u_array (
        .clk     (clk),
        .rst     (reset),
        .i_wen   (w_wen),
        .i_ren   (w_ren),
        .i_addr  (w_adr[ADDR_W+1:2]),
        .i_wdata (w_wd),
        .o_rdata (w_q)
    );

    assign bus.readdata = r_zero ? ERR_DATA : w_q;
    assign bus.ready    = r_state == RESP;
    assign bus.busy     = r_state != IDLE;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_mc_mem_responder.sv
// tb_mc_mem_responder: directed scoreboard bench for LATENCY=2 and LATENCY=0 responders.
module tb_mc_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errs = 0;
    logic [15:0] sb[$];

`ifdef MC_MEM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    always #5 clk = ~clk;

    mc_mem_responder_if b2();
    mc_mem_responder_if b0();

    mc_mem_responder #(.ADDR_W(8), .LATENCY(2)) u2 (.clk(clk), .reset(rst), .bus(b2));
    mc_mem_responder #(.ADDR_W(8), .LATENCY(0)) u0 (.clk(clk), .reset(rst), .bus(b0));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit u, input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        if (u) begin
            b2.req = r; b2.we = w; b2.adr = a; b2.writedata = d;
        end else begin
            b0.req = r; b0.we = w; b0.adr = a; b0.writedata = d;
        end
    endtask

    // One transaction: latency, busy span, err, scoreboard readdata, single-cycle ready.
    task automatic xact(input bit u, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp_rd, input logic exp_err, input string tag);
        int n, nb;
        logic rdy;
        logic [15:0] e;
        @(negedge clk);
        drive(u, 1'b1, w, a, d);
        if (!w) sb.push_back(exp_rd);
        @(posedge clk);
        #1;
        drive(u, 1'b0, w, a, d);
        n = 0; nb = 0; rdy = 1'b0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
            rdy = u ? b2.ready : b0.ready;
            nb += int'(u ? b2.busy : b0.busy);
        end
        chk({tag, " latency"}, 16'(n), u ? 16'd3 : 16'd1);
        chk({tag, " busy_cycles"}, 16'(nb), u ? 16'd3 : 16'd1);
        chk({tag, " err"}, 16'(u ? b2.err : b0.err), 16'(exp_err));
        if (!w) begin
            e = sb.pop_front();
            chk({tag, " readdata"}, u ? b2.readdata : b0.readdata, e);
        end
        @(negedge clk);
        chk({tag, " ready_one_cycle"}, 16'(u ? b2.ready : b0.ready), 16'd0);
        chk({tag, " busy_after"}, 16'(u ? b2.busy : b0.busy), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nr;
        logic [15:0] e;
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst readdata", b2.readdata, 16'h0);
        chk("rst ready", 16'(b2.ready), 16'h0);
        chk("rst busy", 16'(b2.busy), 16'h0);
        chk("rst err", 16'(b2.err), 16'h0);
        chk("rst u0 readdata", b0.readdata, 16'h0);

        xact(1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0, 1'b0, "wr_beef");
        xact(1'b1, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0, "rd_beef");
        repeat (10) @(negedge clk);
        chk("beef hold", b2.readdata, 16'hBEEF);

        xact(1'b0, 1'b1, 16'h0004, 16'h1234, 16'h0, 1'b0, "l0_wr1");
        xact(1'b0, 1'b0, 16'h0004, 16'h0, 16'h1234, 1'b0, "l0_rd1");

        // Continuous req at zero latency: a response every other cycle.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0);
        repeat (5) sb.push_back(16'h1234);
        nr = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (b0.ready) begin
                nr++;
                e = sb.pop_front();
                chk("l0 stream readdata", b0.readdata, e);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0);
        chk("l0 stream pulses", 16'(nr), 16'd5);
        while (sb.size() > 0) void'(sb.pop_front());
        repeat (2) @(negedge clk);

        // Bus changes during WAIT are ignored.
        xact(1'b1, 1'b1, 16'h0020, 16'h5555, 16'h0, 1'b0, "wr_w8");
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 16'h0024, 16'hCAFE);
        @(posedge clk);
        #1;
        b2.adr = 16'h0020;
        b2.writedata = 16'h0000;
        n = 0;
        while (!b2.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        b2.req = 1'b0;
        chk("wait_ignore latency", 16'(n), 16'd3);
        @(negedge clk);
        xact(1'b1, 1'b0, 16'h0020, 16'h0, 16'h5555, 1'b0, "rd_w8");
        xact(1'b1, 1'b0, 16'h0024, 16'h0, 16'hCAFE, 1'b0, "rd_w9");

        // Reset during WAIT discards the pending write.
        xact(1'b1, 1'b1, 16'h0008, 16'h1111, 16'h0, 1'b0, "wr_w2");
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 16'h0008, 16'hAAAA);
        @(posedge clk);
        #1;
        b2.req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        nr = 0;
        repeat (5) begin
            @(negedge clk);
            nr += int'(b2.ready);
        end
        chk("rst_wait no ready", 16'(nr), 16'd0);
        chk("rst_wait readdata", b2.readdata, 16'h0);
        chk("rst_wait busy", 16'(b2.busy), 16'h0);
        xact(1'b1, 1'b0, 16'h0008, 16'h0, 16'h1111, 1'b0, "rd_w2");

        // Out-of-range address: flagged and suppressed, or aliased to word 0.
        xact(1'b1, 1'b1, 16'h0000, 16'h7777, 16'h0, 1'b0, "wr_w0");
        xact(1'b1, 1'b1, 16'h0400, 16'h9999, 16'h0, BC, "wr_oor");
        xact(1'b1, 1'b0, 16'h0000, 16'h0, BC ? 16'h7777 : 16'h9999, 1'b0, "rd_w0");
        xact(1'b1, 1'b0, 16'h0400, 16'h0, BC ? 16'h0000 : 16'h9999, BC, "rd_oor");
        xact(1'b1, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0, "rd_after_oor");

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule
